// File: rtl/aibcr3_dcc_pkg.sv
// Shared types and helpers for the DCC delay-line calibrator.
// FSM states, step direction, phase flag and bin-to-Gray helper.
package aibcr3_dcc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_SETTLE,
    ST_SAMPLE,
    ST_UPDATE
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN
  } dir_e;

  typedef enum logic {
    PH_SAR,
    PH_TRACK
  } phase_e;

  // One Gray bit from a binary bit and its upper neighbour.
  function automatic logic b2g_bit(
    input logic b_up,
    input logic b
  );
    return b_up ^ b;
  endfunction

endpackage

// File: rtl/aibcr3_dcc_b2g.sv
// Combinational binary-to-Gray converter.
// Output bit i is bin[i+1] ^ bin[i]; the MSB passes through.
module aibcr3_dcc_b2g
  import aibcr3_dcc_pkg::*;
#(
  parameter int CODE_W = 11
) (
  input  logic [CODE_W-1:0] i_bin,
  output logic [CODE_W-1:0] o_gray
);

  logic [CODE_W:0] w_ext;

  assign w_ext = {1'b0, i_bin};

  for (genvar i = 0; i < CODE_W; i++) begin : g_bit
    assign o_gray[i] = b2g_bit(w_ext[i+1], w_ext[i]);
  end

endmodule

// File: rtl/aibcr3_dcc_dly_cal.sv
// DCC delay-line calibrator: SAR search, then +/-1 tracking.
// Lock is declared after LOCK_CNT direction reversals.
module aibcr3_dcc_dly_cal
  import aibcr3_dcc_pkg::*;
#(
  parameter int CODE_W     = 11,
  parameter int SETTLE_CYC = 8,
  parameter int LOCK_CNT   = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              cal_en,
  input  logic              pd_early,
  output logic              launch,
  output logic              measure,
  output logic [CODE_W-1:0] gray,
  output logic [CODE_W-1:0] code_bin,
  output logic              dll_lock,
  output logic              cal_busy
);

  localparam int IW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int SW =
    (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int RW = $clog2(LOCK_CNT + 1);

  localparam logic [CODE_W-1:0] MID =
    CODE_W'(1) << (CODE_W - 1);
  localparam logic [CODE_W-1:0] MAXC = '1;
  localparam logic [RW-1:0] REV_MAX = RW'(LOCK_CNT);

  state_e              r_state;
  phase_e              r_phase;
  dir_e                r_prev;
  logic [IW-1:0]       r_idx;
  logic [SW-1:0]       r_cnt;
  logic [RW-1:0]       r_rev;
  logic                r_pd;
  logic                r_launch;
  logic                r_measure;
  logic                r_lock;
  logic [CODE_W-1:0]   r_code_bin;
  logic [CODE_W-1:0]   r_gray;

  logic [CODE_W-1:0]   w_code_nxt;
  logic [CODE_W-1:0]   w_gray_nxt;
  dir_e                w_dir;
  logic                w_sat;
  logic                w_rev;

  assign launch   = r_launch;
  assign measure  = r_measure;
  assign gray     = r_gray;
  assign code_bin = r_code_bin;
  assign dll_lock = r_lock;
  assign cal_busy = (r_state != ST_IDLE);

  // Next code: midscale on start, SAR bit trial or saturating step.
  always_comb begin
    w_code_nxt = r_code_bin;
    w_dir      = r_pd ? DIR_UP : DIR_DOWN;
    w_sat      = 1'b0;
    if (r_state == ST_IDLE) begin
      if (cal_en) w_code_nxt = MID;
    end else if (r_state == ST_UPDATE && cal_en) begin
      if (r_phase == PH_SAR) begin
        w_code_nxt[r_idx] = r_pd;
        if (r_idx != '0)
          w_code_nxt[r_idx - 1'b1] = 1'b1;
      end else if (r_pd) begin
        w_sat = (r_code_bin == MAXC);
        if (!w_sat) w_code_nxt = r_code_bin + 1'b1;
      end else begin
        w_sat = (r_code_bin == '0);
        if (!w_sat) w_code_nxt = r_code_bin - 1'b1;
      end
    end
  end

  assign w_rev = !w_sat
              && (r_prev != DIR_NONE)
              && (w_dir != r_prev);

  aibcr3_dcc_b2g #(
    .CODE_W (CODE_W)
  ) u_b2g (
    .i_bin  (w_code_nxt),
    .o_gray (w_gray_nxt)
  );

  // Calibration FSM with registered strobes, code and lock.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state    <= ST_IDLE;
      r_phase    <= PH_SAR;
      r_prev     <= DIR_NONE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_rev      <= '0;
      r_pd       <= 1'b0;
      r_launch   <= 1'b0;
      r_measure  <= 1'b0;
      r_lock     <= 1'b0;
      r_code_bin <= '0;
      r_gray     <= '0;
    end else begin
      r_code_bin <= w_code_nxt;
      r_gray     <= w_gray_nxt;
      r_launch   <= 1'b0;
      r_measure  <= 1'b0;
      if (r_state != ST_IDLE && !cal_en) begin
        r_state <= ST_IDLE;
        r_lock  <= 1'b0;
        r_rev   <= '0;
        r_prev  <= DIR_NONE;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (cal_en) begin
              r_state   <= ST_LAUNCH;
              r_phase   <= PH_SAR;
              r_idx     <= IW'(CODE_W - 1);
              r_prev    <= DIR_NONE;
              r_rev     <= '0;
              r_launch  <= 1'b1;
              r_measure <= 1'b1;
            end
          end
          ST_LAUNCH: begin
            r_cnt   <= SW'(SETTLE_CYC - 1);
            r_state <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (r_cnt == '0) r_state <= ST_SAMPLE;
            else r_cnt <= r_cnt - 1'b1;
          end
          ST_SAMPLE: begin
            r_pd    <= pd_early;
            r_state <= ST_UPDATE;
          end
          ST_UPDATE: begin
            r_state   <= ST_LAUNCH;
            r_launch  <= 1'b1;
            r_measure <= 1'b1;
            if (r_phase == PH_SAR) begin
              if (r_idx == '0) r_phase <= PH_TRACK;
              else r_idx <= r_idx - 1'b1;
            end else if (!w_sat) begin
              r_prev <= w_dir;
              if (w_rev && r_rev != REV_MAX)
                r_rev <= r_rev + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
        if (r_rev == REV_MAX) r_lock <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aibcr3_dcc_dly_cal.sv
// Bench for aibcr3_dcc_dly_cal: threshold-model table runs,
// abort/restart and async reset sequences, two settle lengths.
module tb_aibcr3_dcc_dly_cal;

  localparam int P8 = 8 + 3;
  localparam int P1 = 1 + 3;
  localparam int M_END = 250;

  typedef struct {
    int thr;
    int fin;
    int gry;
    bit lck;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstb;
  logic        cal_en;
  int          thr;

  logic        pd8, launch8, measure8, lock8, busy8;
  logic [10:0] code8, gray8;
  logic        pd1, launch1, measure1, lock1, busy1;
  logic [10:0] code1, gray1;

  int nvec = 0;
  int nbad = 0;
  int q8[$];
  int q1[$];
  vec_t tbl[5];

  always #5 clk = ~clk;

  assign pd8 = (int'(code8) < thr);
  assign pd1 = (int'(code1) < thr);

  aibcr3_dcc_dly_cal u8 (
    .clk      (clk),
    .rstb     (rstb),
    .cal_en   (cal_en),
    .pd_early (pd8),
    .launch   (launch8),
    .measure  (measure8),
    .gray     (gray8),
    .code_bin (code8),
    .dll_lock (lock8),
    .cal_busy (busy8)
  );

  aibcr3_dcc_dly_cal #(
    .SETTLE_CYC (1)
  ) u1 (
    .clk      (clk),
    .rstb     (rstb),
    .cal_en   (cal_en),
    .pd_early (pd1),
    .launch   (launch1),
    .measure  (measure1),
    .gray     (gray1),
    .code_bin (code1),
    .dll_lock (lock1),
    .cal_busy (busy1)
  );

  task automatic check(
    input string nm,
    input int act,
    input int exp
  );
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Code shown at launch n for pd = (code < t).
  function automatic int exp_code(input int t, input int n);
    int acc = 0;
    int trial;
    int c;
    for (int b = 10; b >= 0; b--) begin
      trial = acc | (1 << b);
      if (n == 10 - b) return trial;
      if (trial < t) acc = trial;
    end
    c = acc;
    for (int k = 11; k < n; k++) begin
      if (c < t) begin
        if (c < 2047) c++;
      end else if (c > 0) begin
        c--;
      end
    end
    return c;
  endfunction

  task automatic run_vec(input vec_t v);
    int lm = 0, wd = 0, busy = 0, hold = 0, extra = 0;
    int sp8 = 0, sp1 = 0;
    int last8 = -1, last1 = -1;
    int first8 = -1, first1 = -1;
    int lk8 = -1, lk1 = -1;
    logic pl8 = 1'b0, pl1 = 1'b0;
    int c8, c1, g8, g1;
    thr = v.thr;
    q8.delete();
    q1.delete();
    for (int n = 0; n * P8 <= M_END; n++)
      q8.push_back(exp_code(v.thr, n));
    for (int n = 0; n * P1 <= M_END; n++)
      q1.push_back(exp_code(v.thr, n));
    cal_en = 1'b1;
    @(posedge clk);
    for (int m = 0; m <= M_END; m++) begin
      @(negedge clk);
      if (launch8 !== measure8) lm++;
      if (launch1 !== measure1) lm++;
      if (busy8 !== 1'b1 || busy1 !== 1'b1) busy++;
      if (launch8) begin
        if (pl8) wd++;
        if (first8 < 0) first8 = m;
        if (last8 >= 0 && m - last8 != P8) sp8++;
        last8 = m;
        if (q8.size() == 0) extra++;
        else check("sb8", int'(code8), q8.pop_front());
      end
      if (launch1) begin
        if (pl1) wd++;
        if (first1 < 0) first1 = m;
        if (last1 >= 0 && m - last1 != P1) sp1++;
        last1 = m;
        if (q1.size() == 0) extra++;
        else check("sb1", int'(code1), q1.pop_front());
      end
      pl8 = launch8;
      pl1 = launch1;
      if (lock8) begin
        if (lk8 < 0) lk8 = m;
      end else if (lk8 >= 0) hold++;
      if (lock1) begin
        if (lk1 < 0) lk1 = m;
      end else if (lk1 >= 0) hold++;
      if (m == 11 * P8) begin
        check("sar8_code", int'(code8), v.fin);
        check("sar8_gray", int'(gray8), v.gry);
      end
      if (m == 11 * P1) begin
        check("sar1_code", int'(code1), v.fin);
        check("sar1_gray", int'(gray1), v.gry);
      end
    end
    check("first_launch8", first8, 0);
    check("first_launch1", first1, 0);
    check("launch_eq_measure", lm, 0);
    check("launch_width", wd, 0);
    check("spacing8", sp8, 0);
    check("spacing1", sp1, 0);
    check("busy_high", busy, 0);
    check("lock_held", hold, 0);
    check("extra_launch", extra, 0);
    check("missing_launch", q8.size() + q1.size(), 0);
    check("lock8_cyc", lk8, v.lck ? 16 * P8 + 1 : -1);
    check("lock1_cyc", lk1, v.lck ? 16 * P1 + 1 : -1);
    c8 = int'(code8);
    c1 = int'(code1);
    g8 = int'(gray8);
    g1 = int'(gray1);
    cal_en = 1'b0;
    @(negedge clk);
    check("drop_busy", int'({busy8, busy1}), 0);
    check("drop_launch", int'({launch8, measure8}), 0);
    check("drop_lock", int'({lock8, lock1}), 0);
    check("drop_code8", int'(code8), c8);
    check("drop_gray8", int'(gray8), g8);
    check("drop_code1", int'(code1), c1);
    check("drop_gray1", int'(gray1), g1);
  endtask

  initial begin
    int nl;
    int nc;
    tbl[0] = '{700, 699, 998, 1'b1};
    tbl[1] = '{2048, 2047, 1024, 1'b0};
    tbl[2] = '{0, 0, 0, 1'b0};
    tbl[3] = '{1, 0, 0, 1'b1};
    tbl[4] = '{1500, 1499, 1846, 1'b1};

    rstb   = 1'b0;
    cal_en = 1'b0;
    thr    = 700;
    repeat (3) @(negedge clk);
    check("rst_code", int'(code8), 0);
    check("rst_gray", int'(gray8), 0);
    check("rst_strobe", int'({launch8, measure8}), 0);
    check("rst_lock_busy", int'({lock8, busy8}), 0);
    rstb = 1'b1;
    @(negedge clk);
    check("idle_busy", int'({busy8, busy1}), 0);

    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

    // Abort in SETTLE of SAR iteration 5, then restart.
    thr    = 700;
    cal_en = 1'b1;
    @(posedge clk);
    for (int m = 0; m <= 4 * P8 + 3; m++) @(negedge clk);
    cal_en = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy8), 0);
    check("abort_code", int'(code8), 704);
    check("abort_gray", int'(gray8), 928);
    check("abort_launch", int'(launch8), 0);
    nl = 0;
    nc = 0;
    for (int m = 0; m < 20; m++) begin
      @(negedge clk);
      if (launch8 || measure8) nl++;
      if (code8 != 11'd704) nc++;
    end
    check("idle_no_launch", nl, 0);
    check("idle_code_held", nc, 0);
    cal_en = 1'b1;
    @(negedge clk);
    check("restart_code", int'(code8), 1024);
    check("restart_gray", int'(gray8), 1536);
    check("restart_launch", int'({launch8, measure8}), 3);

    // Async reset mid-launch after lock.
    for (int m = 1; m <= 18 * P8; m++) @(negedge clk);
    check("pre_rst_lock", int'(lock8), 1);
    check("pre_rst_launch", int'(launch8), 1);
    #2;
    rstb = 1'b0;
    #1;
    check("arst_code", int'(code8), 0);
    check("arst_gray", int'(gray8), 0);
    check("arst_strobe", int'({launch8, measure8}), 0);
    check("arst_lock_busy", int'({lock8, busy8}), 0);
    check("arst_u1", int'({lock1, busy1, launch1}), 0);
    check("arst_code1", int'(code1), 0);
    cal_en = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    check("post_rst_idle", int'({busy8, launch8}), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule

// File: doc/aibcr3_dcc_dly_cal.md
AIBCR3_DCC_DLY_CAL -- requirements
Module: aibcr3_dcc_dly_cal

Interface
REQ-001 Parameter CODE_W, default 11, delay-line code width in bits.
REQ-002 Parameter SETTLE_CYC, default 8, cycles to wait between launch and phase-detector sampling; legal range is >=1.
REQ-003 Parameter LOCK_CNT, default 4, direction reversals in tracking that declare lock; legal range is >=1.
REQ-004 The block SHALL use one clock and one reset; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rstb  in  1  asynchronous, active-low reset.
REQ-007 cal_en  in  1  level; 1 runs calibration and tracking, 0 returns to idle.
REQ-008 pd_early  in  1  phase-detector result, synchronous to clk; 1 means the delay line is too short.
REQ-009 launch  out  1  one-cycle pulse into the delay-line path.
REQ-010 measure  out  1  one-cycle pulse into the min-delay path, coincident with launch.
REQ-011 gray  out  CODE_W  registered Gray-coded delay code.
REQ-012 code_bin  out  CODE_W  registered binary delay code.
REQ-013 dll_lock  out  1  lock indication.
REQ-014 cal_busy  out  1  high whenever the state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, LAUNCH, SETTLE, SAMPLE and UPDATE, plus a 1-bit phase flag with values SAR and TRACK.
REQ-016 IDLE with cal_en=1: next cycle go to LAUNCH, set phase=SAR, code_bin=1<<(CODE_W-1), bit index=CODE_W-1, prev_dir=NONE, rev_cnt=0.
REQ-017 LAUNCH: launch=1 and measure=1 for exactly this cycle; load settle counter with SETTLE_CYC-1; go to SETTLE.
REQ-018 SETTLE: decrement the counter each cycle; when it is 0, go to SAMPLE, so SETTLE lasts SETTLE_CYC cycles.
REQ-019 SAMPLE: register pd_early; go to UPDATE.
REQ-020 UPDATE in SAR phase:
- If the sampled pd_early=0, clear code bit[index]; otherwise keep it.
- If index>0, set bit[index-1], decrement index, and go to LAUNCH.
- If index=0, set phase=TRACK and go to LAUNCH.
REQ-021 UPDATE in TRACK phase:
- Sampled pd_early=1 selects direction UP (code+1); pd_early=0 selects DOWN (code-1).
- Saturate the code at 2^CODE_W-1 and at 0; a saturated step leaves the code unchanged and does not change prev_dir.
REQ-022 Reversal counting in TRACK:
- A non-saturated step whose direction differs from a prev_dir that is not NONE increments rev_cnt.
- rev_cnt saturates at LOCK_CNT.
- prev_dir is then updated to the step direction.
REQ-023 dll_lock SHALL be set in the cycle after rev_cnt reaches LOCK_CNT, and SHALL stay set while cal_en=1; tracking continues after lock.
REQ-024 One iteration SHALL be exactly SETTLE_CYC+3 cycles; the first LAUNCH SHALL occur 1 cycle after cal_en is sampled high.
REQ-025 gray SHALL equal code_bin ^ (code_bin>>1), registered in the same cycle as code_bin, so gray never lags code_bin.
REQ-026 cal_en=0 in any state other than IDLE:
- Next state is IDLE.
- launch, measure and dll_lock are forced low next cycle.
- code_bin and gray retain their values.
- rev_cnt and prev_dir are cleared.
REQ-027 A cal_en re-rise SHALL restart the full SAR sequence from the midscale code.

Reset
REQ-028 While rstb=0, the block SHALL hold state=IDLE, code_bin=0, gray=0, launch=0, measure=0, dll_lock=0, cal_busy=0, and clear all counters.
REQ-029 Reset assertion is asynchronous; deassertion SHALL be synchronised externally, and the first active edge sees IDLE.

Structure
REQ-030 The FSM state enum, the direction enum (NONE/UP/DOWN) and a bin-to-Gray function SHALL live in shared package aibcr3_dcc_pkg.
REQ-031 One sub-module aibcr3_dcc_b2g (parametrised CODE_W, combinational bin-to-Gray) is natural; all registers stay in the top module.

Verification
REQ-032 Defaults, model pd_early=(code_bin<700), cal_en rises -> SAR ends at code_bin=699 after 121 cycles; dll_lock=1 exactly 177 cycles after cal_en is sampled high; gray=998 when code_bin=699.
REQ-033 pd_early held at 1 -> code_bin=2047 after SAR, stays 2047 in tracking, dll_lock never asserts.
REQ-034 pd_early held at 0 -> code_bin=0 after SAR, stays 0, dll_lock never asserts.
REQ-035 cal_en dropped during SETTLE of SAR iteration 5 -> IDLE next cycle, code_bin retained, no launch pulse; cal_en re-rise -> code_bin=1024 and launch 1 cycle later.
REQ-036 rstb pulsed low mid-TRACK after lock -> all outputs 0 immediately, without a clock edge.
REQ-037 Every launch pulse is exactly one cycle, coincident with measure, and consecutive launches are spaced exactly SETTLE_CYC+3 cycles; check at SETTLE_CYC=1 and at SETTLE_CYC=8.
